// File: rtl/l2_pkg.sv
// l2_pkg: shared types, sizes and output saturation for the layer-2 convolution engine.
package l2_pkg;
    localparam int DW   = 18;
    localparam int TAPS = 18;
    localparam int NWIN = 121;
    localparam int FRAC = 10;
    localparam int ACCW = 44;
    localparam int TCW  = $clog2(TAPS);
    localparam int WCW  = $clog2(NWIN);

    typedef logic signed [DW-1:0]   data_t;
    typedef logic signed [ACCW-1:0] acc_t;
    typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;

    localparam acc_t SMAX = acc_t'(2**(DW-1) - 1);
    localparam acc_t SMIN = -SMAX - acc_t'(1);

    function automatic data_t sat_dw(input acc_t a);
        acc_t s;
        s = a >>> FRAC;
        return (s > SMAX) ? data_t'(SMAX) : (s < SMIN) ? data_t'(SMIN) : data_t'(s);
    endfunction
endpackage

// File: rtl/l2_mac.sv
// l2_mac: signed multiply-accumulate with bias preload; exposes the next accumulator value.
module l2_mac
    import l2_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   acc_en,
    input  logic signed [DW-1:0]   init,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] sum
);
    acc_t acc_q, acc_d;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        prod  = a * b;
        acc_d = clr ? (ACCW'(init) <<< FRAC) : acc_en ? acc_q + ACCW'(prod) : acc_q;
    end

    assign sum = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

// File: rtl/l2_conv_engine.sv
// l2_conv_engine: captures 3x3x2 pooled windows, 18-tap MAC with bias, rescale and saturate.
// Optional L2_RELU_EN clamps negative results to zero.
module l2_conv_engine
    import l2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               rd,
    input  logic [DW*TAPS-1:0] din,
    input  logic [DW*TAPS-1:0] wt,
    input  logic [DW-1:0]      bias,
    output logic               addr_rd_inc,
    output logic [DW-1:0]      res,
    output logic               res_vld,
    output logic               tx_done,
    output logic               busy
);
    state_t         state_q, state_d;
    data_t          win_q [TAPS];
    data_t          win_d [TAPS];
    data_t          wt_a  [TAPS];
    logic [TCW-1:0] tap_cnt_q, tap_cnt_d;
    logic [WCW-1:0] win_cnt_q, win_cnt_d;
    data_t          res_q, res_d, res_sat, sat_v;
    logic           addr_rd_inc_q, res_vld_q, tx_done_q, busy_q;
    logic           mac_clr, mac_en, last_tap, last_win;
    acc_t           acc_nxt;

    always_comb for (int i = 0; i < TAPS; i++) wt_a[i] = data_t'(wt[i*DW +: DW]);

    assign last_tap = tap_cnt_q == TCW'(TAPS-1);
    assign last_win = win_cnt_q == WCW'(NWIN-1);
    assign sat_v    = sat_dw(acc_nxt);
`ifdef L2_RELU_EN
    assign res_sat  = sat_v[DW-1] ? '0 : sat_v;
`else
    assign res_sat  = sat_v;
`endif

    l2_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .acc_en (mac_en),
        .init   (data_t'(bias)),
        .a      (win_q[tap_cnt_q]),
        .b      (wt_a[tap_cnt_q]),
        .sum    (acc_nxt)
    );

    // res is captured from the final MAC sum so it is valid in the same cycle as res_vld
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        tap_cnt_d = tap_cnt_q;
        win_cnt_d = win_cnt_q;
        res_d     = res_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            IDLE: state_d = (en && rd) ? LOAD : IDLE;
            LOAD: begin
                for (int i = 0; i < TAPS; i++) win_d[i] = data_t'(din[i*DW +: DW]);
                mac_clr   = 1'b1;
                tap_cnt_d = '0;
                state_d   = MAC;
            end
            MAC: begin
                mac_en    = 1'b1;
                tap_cnt_d = last_tap ? '0 : tap_cnt_q + 1'b1;
                state_d   = last_tap ? OUT : MAC;
                res_d     = last_tap ? res_sat : res_q;
            end
            OUT: begin
                state_d   = last_win ? DONE : IDLE;
                win_cnt_d = last_win ? '0 : win_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            win_q         <= '{default: '0};
            tap_cnt_q     <= '0;
            win_cnt_q     <= '0;
            res_q         <= '0;
            addr_rd_inc_q <= 1'b0;
            res_vld_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            tap_cnt_q     <= tap_cnt_d;
            win_cnt_q     <= win_cnt_d;
            res_q         <= res_d;
            addr_rd_inc_q <= state_d == LOAD;
            res_vld_q     <= state_d == OUT;
            tx_done_q     <= state_d == DONE;
            busy_q        <= state_d != IDLE;
        end
    end

    assign addr_rd_inc = addr_rd_inc_q;
    assign res         = res_q;
    assign res_vld     = res_vld_q;
    assign tx_done     = tx_done_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_l2_conv_engine.sv
// tb_l2_conv_engine: directed vector table plus reset, enable and full-frame sequences.
module tb_l2_conv_engine;
    import l2_pkg::*;

    logic               clk = 1'b0, rst_n = 1'b0, en = 1'b0, rd = 1'b0;
    logic [DW*TAPS-1:0] din = '0, wt = '0;
    logic [DW-1:0]      bias = '0;
    logic               addr_rd_inc, res_vld, tx_done, busy;
    logic signed [DW-1:0] res;
    int total = 0, passed = 0, wins = 0;

    always #5 clk = ~clk;

    l2_conv_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rd          (rd),
        .din         (din),
        .wt          (wt),
        .bias        (bias),
        .addr_rd_inc (addr_rd_inc),
        .res         (res),
        .res_vld     (res_vld),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    typedef struct { int d; int w; int b; int e; string nm; } vec_t;
    vec_t tv [8];

    function automatic logic [DW*TAPS-1:0] rep(input int v);
        logic [DW*TAPS-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic int relu(input int v);
`ifdef L2_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // rd is presented in period 0; LOAD is period 1, res_vld is expected in period 20
    task automatic run_win(input int d, input int w, input int b, input int e, input string nm,
                           input bit drop_en);
        bit early;
        early = 1'b0;
        din = rep(d); wt = rep(w); bias = DW'(b); rd = 1'b1; en = 1'b1;
        tick;
        chk({nm, " addr_rd_inc"}, addr_rd_inc, 1);
        rd = 1'b0;
        tick;
        din = ~din;
        for (int k = 2; k < 20; k++) begin
            if (res_vld || addr_rd_inc) early = 1'b1;
            if (drop_en && k == 5) begin en = 1'b0; rd = 1'b1; end
            tick;
        end
        chk({nm, " res_vld"}, res_vld, 1);
        chk({nm, " res"}, res, relu(e));
        chk({nm, " no early pulse"}, early, 0);
        wins++;
        tick;
        chk({nm, " tx_done"}, tx_done, wins == NWIN);
        if (wins == NWIN) begin wins = 0; tick; end
    endtask

    initial begin
        int cnt, bcnt, frames, nv, ni, last, gap_bad;
        tv[0] = '{1024, 1024, 0, 18432, "unit"};
        tv[1] = '{131071, 131071, 0, 131071, "pos_sat"};
        tv[2] = '{131071, -131071, 0, -131072, "neg_sat"};
        tv[3] = '{1024, -1024, 0, -18432, "neg"};
        tv[4] = '{1024, 1024, 100, 18532, "bias"};
        tv[5] = '{2048, -512, 5000, -13432, "mixed"};
        tv[6] = '{3, 5, 0, 0, "tiny_pos"};
        tv[7] = '{-3, 5, 0, -1, "tiny_neg"};

        #12;
        chk("rst addr_rd_inc", addr_rd_inc, 0);
        chk("rst res", res, 0);
        chk("rst res_vld", res_vld, 0);
        chk("rst tx_done", tx_done, 0);
        chk("rst busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) run_win(tv[i].d, tv[i].w, tv[i].b, tv[i].e, tv[i].nm, 1'b0);

        cnt = 0; bcnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            cnt += int'(addr_rd_inc) + int'(res_vld) + int'(tx_done);
            bcnt += int'(busy);
        end
        chk("idle pulses", cnt, 0);
        chk("idle busy", bcnt, 0);

        en = 1'b0; rd = 1'b1; cnt = 0; bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            cnt += int'(addr_rd_inc);
            bcnt += int'(busy);
        end
        chk("en0 addr_rd_inc", cnt, 0);
        chk("en0 busy", bcnt, 0);

        run_win(1024, 1024, 0, 18432, "en_drop", 1'b1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            cnt += int'(addr_rd_inc) + int'(busy);
        end
        chk("en_drop holds idle", cnt, 0);
        rd = 1'b0; en = 1'b1;
        tick;

        din = rep(1024); wt = rep(1024); bias = '0; rd = 1'b1; en = 1'b1;
        tick;
        rd = 1'b0;
        repeat (8) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst addr_rd_inc", addr_rd_inc, 0);
        chk("mid rst res", res, 0);
        chk("mid rst res_vld", res_vld, 0);
        chk("mid rst tx_done", tx_done, 0);
        chk("mid rst busy", busy, 0);
        cnt = 0;
        repeat (3) begin @(negedge clk); cnt += int'(res_vld); end
        chk("mid rst no res_vld", cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        wins = 0;
        tick;
        run_win(tv[0].d, tv[0].w, tv[0].b, tv[0].e, "post_rst", 1'b0);

        rd = 1'b1; en = 1'b1;
        frames = 0; nv = 0; ni = 0; last = -100; gap_bad = 0;
        for (int c = 0; c < 8000 && frames < 2; c++) begin
            tick;
            if (addr_rd_inc) ni++;
            if (res_vld) begin
                if (nv > 0 && c - last != 21) gap_bad++;
                nv++;
                last = c;
            end
            if (tx_done) begin
                chk("frame res_vld count", nv, frames == 0 ? NWIN - wins : NWIN);
                chk("frame addr_rd_inc count", ni, frames == 0 ? NWIN - wins : NWIN);
                chk("tx_done after last res_vld", c - last, 1);
                frames++;
                nv = 0; ni = 0;
            end
        end
        chk("frames completed", frames, 2);
        chk("window period", gap_bad, 0);
        rd = 1'b0;
        tick;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
